button_conditioner: RTL and testbench

Input-conditioning stage for the parking meter's six front-panel buttons (+10, +180, +200, +550, reset-to-10, reset-to-205). It synchronizes each raw switch into `clk`, debounces it, and turns each debounced press into a single-cycle pulse. At most one pulse is issued per cycle, so the downstream seconds counter always sees a one-hot or all-zero command vector. The block sits between the board pins and the meter counter.

---
 rtl/parking_pkg.sv | 30 +++
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/button_conditioner.sv | 88 ++++++++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// ----------------------------------------------------------------------------
// parking_pkg
// Shared constants for the parking meter front panel.
//
// Contents:
//   N_BTN                    number of front-panel buttons
//   BTN_*                    bit index of each button in every button vector
//   DEFAULT_SYNC_STAGES      synchronizer depth used unless overridden
//   DEFAULT_DEBOUNCE_CYCLES  stable samples needed to accept a level change
//                            (10 ms at 100 MHz)
//   btn_vec_t                one bit per button, indexed by BTN_*
// ----------------------------------------------------------------------------
package parking_pkg;

  localparam int N_BTN = 6;

  // Button IDs double as bit positions; lower index wins arbitration.
  localparam int BTN_PLUS10  = 0;
  localparam int BTN_PLUS180 = 1;
  localparam int BTN_PLUS200 = 2;
  localparam int BTN_PLUS550 = 3;
  localparam int BTN_RST10   = 4;
  localparam int BTN_RST205  = 5;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef logic [N_BTN-1:0] btn_vec_t;

endpackage : parking_pkg

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One button's conditioning path: a SYNC_STAGES-deep synchronizer, a
// debounce counter and the accepted (debounced) level. A rise strobe marks
// the edge at which the accepted level goes 0 -> 1.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst    in   synchronous, active-high reset
//   raw    in   asynchronous, bouncy button input (active-high)
//   level  out  debounced level (registered)
//   rise   out  high during the cycle whose closing edge sets level to 1;
//               derived only from registers, never from raw
// ----------------------------------------------------------------------------
module debounce_channel
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Terminal count: the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_next;
  logic                   level_q;
  logic                   level_next;
  logic                   rise_c;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Synchronizer: raw enters at bit 0 and shifts toward the MSB.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: any sample that agrees with the accepted level restarts the
  // count, so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples
  // flips the level.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_next   = cnt_q;
    level_next = level_q;
    rise_c     = 1'b0;
    if (sync_out == level_q) begin
      cnt_next = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_next   = '0;
      level_next = ~level_q;
      rise_c     = ~level_q;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      level_q <= level_next;
    end
  end

  assign level = level_q;
  // Reset forces the strobe low so the parent's pending register stays clear.
  assign rise  = rise_c & ~rst;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Front-panel input stage for the parking meter. Each raw button is
// synchronized and debounced by its own debounce_channel; every accepted
// press is latched in a pending bit and then issued as a single-cycle pulse.
// At most one pulse leaves per cycle (lowest index first), so the command
// vector seen by the seconds counter is always one-hot or zero.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   btn_raw      in   [N_BTN] asynchronous, bouncy buttons (active-high)
//   btn_level    out  [N_BTN] debounced levels (registered)
//   btn_pulse    out  [N_BTN] press pulses, one-hot or zero (registered)
//   pulse_valid  out  OR of btn_pulse, registered on the same edge
//
// Handshake: btn_pulse/pulse_valid form a valid-only stream. There is no
// ready; the consumer must accept each pulse in the one cycle it is shown.
// Presses that arrive together wait in pending and are issued on
// consecutive cycles in ascending index order, none dropped or merged.
// ----------------------------------------------------------------------------
module button_conditioner
  import parking_pkg::*;
#(
  parameter int N_BTN           = parking_pkg::N_BTN,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             pulse_valid
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] rise_w;

  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] pending_next;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pulse_q;
  logic             valid_q;

  // --------------------------------------------------------------------------
  // One conditioning channel per button.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (level_w[i]),
      .rise  (rise_w[i])
    );
  end

  // --------------------------------------------------------------------------
  // Arbiter: isolate the lowest set pending bit (x & -x). The granted bit is
  // removed from pending, but a rise on the same edge re-sets it, so a new
  // press is never lost to a concurrent grant.
  // --------------------------------------------------------------------------
  always_comb begin
    grant        = pending_q & (~pending_q + N_BTN'(1));
    pending_next = (pending_q & ~grant) | rise_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      pulse_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_next;
      pulse_q   <= grant;
      valid_q   <= |grant;
    end
  end

  assign btn_level   = level_w;
  assign btn_pulse   = pulse_q;
  assign pulse_valid = valid_q;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A vector table covers reset, a clean press/release and a too-short press;
// hand-written sequences cover bouncing, simultaneous presses, reset with
// presses pending and a button held through reset.
// Inputs change 1 ns after a rising edge; outputs are checked at that time.
// ----------------------------------------------------------------------------
module tb_button_conditioner;
  import parking_pkg::*;

  localparam int NB = 6;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          pulse_valid;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (NB),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .pulse_valid (pulse_valid)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  logic [NB-1:0] exp_q[$];

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pls;
  } vec_t;

  vec_t vecs[$];

  // --------------------------------------------------------------------------
  // Driver / checker tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NB-1:0] act,
                       input logic [NB-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_out(input string name, input logic [NB-1:0] lvl,
                           input logic [NB-1:0] pls);
    check({name, "_level"}, btn_level, lvl);
    check({name, "_pulse"}, btn_pulse, pls);
    check({name, "_valid"}, NB'(pulse_valid), NB'(|pls));
  endtask

  task automatic add(input logic r, input logic [NB-1:0] raw,
                     input logic [NB-1:0] lvl, input logic [NB-1:0] pls);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = lvl; v.pls = pls;
    vecs.push_back(v);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [4:0] bounce_pat;
    logic [NB-1:0] exp_l;
    logic [NB-1:0] exp_p;

    rst     = 1'b1;
    btn_raw = '0;

    // Reset state.
    add(1'b1, 6'b000000, 6'b000000, 6'b000000);
    add(1'b1, 6'b000000, 6'b000000, 6'b000000);
    // Clean press of bit 0 (row k = state after edge k), then release.
    for (int e = 0; e < 8; e++)
      add(1'b0, 6'b000001, (e >= 5) ? 6'b000001 : 6'b000000,
          (e == 6) ? 6'b000001 : 6'b000000);
    for (int e = 8; e < 15; e++)
      add(1'b0, 6'b000000, (e < 13) ? 6'b000001 : 6'b000000, 6'b000000);
    // Bit 4 high for only 3 samples: never accepted.
    for (int e = 0; e < 8; e++)
      add(1'b0, (e < 3) ? 6'b010000 : 6'b000000, 6'b000000, 6'b000000);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      btn_raw = vecs[i].raw;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pls);
    end

    // Bit 2 bounces 1,0,1,0,1 then holds 1; released at edge 12.
    bounce_pat = 5'b10101;
    for (int e = 0; e < 20; e++) begin
      if (e < 5)       btn_raw = {3'b000, bounce_pat[e], 2'b00};
      else if (e < 12) btn_raw = 6'b000100;
      else             btn_raw = 6'b000000;
      tick();
      exp_l = (e >= 9 && e < 17) ? 6'b000100 : 6'b000000;
      exp_p = (e == 10) ? 6'b000100 : 6'b000000;
      check_out($sformatf("bounce_e%0d", e), exp_l, exp_p);
    end

    // Bits 1, 3, 5 pressed together: delivered in ascending order.
    exp_q.push_back(6'b000010);
    exp_q.push_back(6'b001000);
    exp_q.push_back(6'b100000);
    for (int e = 0; e < 16; e++) begin
      btn_raw = (e < 10) ? 6'b101010 : 6'b000000;
      tick();
      exp_l = (e >= 5 && e < 15) ? 6'b101010 : 6'b000000;
      case (e)
        6:       exp_p = 6'b000010;
        7:       exp_p = 6'b001000;
        8:       exp_p = 6'b100000;
        default: exp_p = 6'b000000;
      endcase
      check_out($sformatf("simul_e%0d", e), exp_l, exp_p);
      if (pulse_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL simul_extra: got pulse %b, expected none", btn_pulse);
        end else begin
          check("simul_order", btn_pulse, exp_q.pop_front());
        end
      end
    end
    check("simul_drained", NB'(exp_q.size()), 6'd0);

    // Bits 0 and 1 become pending at edge 5; reset at edge 6 discards both.
    for (int e = 0; e < 6; e++) begin
      btn_raw = 6'b000011;
      tick();
      check_out($sformatf("rstpend_e%0d", e),
                (e >= 5) ? 6'b000011 : 6'b000000, 6'b000000);
    end
    rst     = 1'b1;
    btn_raw = 6'b000000;
    tick();
    check_out("rstpend_clear", 6'b000000, 6'b000000);
    tick();
    check_out("rstpend_hold", 6'b000000, 6'b000000);
    rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check_out($sformatf("rstpend_after%0d", e), 6'b000000, 6'b000000);
    end

    // Bit 5 pressed, then held through reset: fresh press afterwards.
    for (int e = 0; e < 10; e++) begin
      btn_raw = 6'b100000;
      tick();
      check_out($sformatf("held_pre%0d", e), (e >= 5) ? 6'b100000 : 6'b000000,
                (e == 6) ? 6'b100000 : 6'b000000);
    end
    rst = 1'b1;
    tick();
    check_out("held_rst0", 6'b000000, 6'b000000);
    tick();
    check_out("held_rst1", 6'b000000, 6'b000000);
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      check_out($sformatf("held_post%0d", e), (e >= 5) ? 6'b100000 : 6'b000000,
                (e == 6) ? 6'b100000 : 6'b000000);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_button_conditioner
